genome_mutate: RTL and testbench

//  Bitwise mutation stage directly downstream of the crossover/selection unit.

---
 rtl/ga_pkg.sv | 14 +
 rtl/ga_lfsr32.sv | 24 ++
 rtl/genome_mutate.sv | 173 +++++++++++++++++
 tb/tb_genome_mutate.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared GA pipeline types and constants: genome width default, LFSR taps/seed, mutate FSM states.
package ga_pkg;

  localparam int          WORD_SZ_DEF   = 64;
  localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_0001;

  typedef enum logic [1:0] {IDLE, MUTATE, OUT} mut_state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/ga_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load (zero seed forced to 1) and advance enable.
module ga_lfsr32
  import ga_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= SEED;
    else if (load)
      q <= (seed == 32'h0) ? 32'h1 : seed;
    else if (advance)
      q <= lfsr_step(q);
  end

endmodule

// File: rtl/genome_mutate.sv
// Chunk-serial genome mutation stage: one chunk per cycle, at most one LFSR-chosen bit flip per chunk.
// Optional MUT_STATS_EN adds saturating stat_flips / stat_genomes counters.
module genome_mutate
  import ga_pkg::*;
#(
  parameter int          WORD_SZ  = WORD_SZ_DEF,
  parameter int          CHUNK_W  = 8,
  parameter logic [31:0] SEED_DEF = LFSR_SEED_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_wr,
  input  logic [7:0]                            cfg_rate,
  input  logic                                  cfg_seed_ld,
  input  logic [31:0]                           cfg_seed,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WORD_SZ-1:0]                    in_genome,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WORD_SZ-1:0]                    out_genome,
  output logic [$clog2(WORD_SZ/CHUNK_W+1)-1:0] out_nflips,
  output logic                                  busy
`ifdef MUT_STATS_EN
  ,
  output logic [15:0]                           stat_flips,
  output logic [15:0]                           stat_genomes
`endif
);

  localparam int NCH = WORD_SZ / CHUNK_W;
  localparam int NW  = $clog2(NCH + 1);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
  localparam int BW  = (WORD_SZ > 1) ? $clog2(WORD_SZ) : 1;

  mut_state_t          state, state_nxt;
  logic [WORD_SZ-1:0]  genome;
  logic [NW-1:0]       nflips;
  logic [IW-1:0]       idx;
  logic [7:0]          rate;

  logic                pend_vld, pend_seed_ld;
  logic [7:0]          pend_rate;
  logic [31:0]         pend_seed;

  logic                apply_now, eff_seed_ld;
  logic [7:0]          eff_rate;
  logic [31:0]         eff_seed;
  logic [31:0]         lfsr_q;
  logic                lfsr_unused;
  logic [7:0]          rnd8;
  logic [PW-1:0]       pos;
  logic                hit, last, accept;
  logic [BW-1:0]       bit_sel;
  logic [WORD_SZ-1:0]  flip_mask;

  // Config only lands in IDLE; a fresh write wins over the deferred one.
  assign apply_now   = (state == IDLE) && (cfg_wr || pend_vld);
  assign eff_rate    = cfg_wr ? cfg_rate    : pend_rate;
  assign eff_seed_ld = cfg_wr ? cfg_seed_ld : pend_seed_ld;
  assign eff_seed    = cfg_wr ? cfg_seed    : pend_seed;

  ga_lfsr32 #(.SEED(SEED_DEF)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (apply_now && eff_seed_ld),
    .seed    (eff_seed),
    .advance (state == MUTATE),
    .q       (lfsr_q)
  );

  assign rnd8        = lfsr_q[7:0];
  assign pos         = lfsr_q[8 +: PW];
  assign lfsr_unused = ^lfsr_q[31:8+PW];
  assign hit         = (state == MUTATE) && (rnd8 < rate);
  assign last        = (idx == IW'(NCH - 1));
  assign accept      = (state == IDLE) && in_valid;
  assign bit_sel     = BW'(idx) * BW'(CHUNK_W) + BW'(pos);

  always_comb begin
    flip_mask = '0;
    if (hit)
      flip_mask[bit_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    out_genome = genome;
    out_nflips = nflips;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid)
          state_nxt = MUTATE;
      end
      MUTATE: begin
        if (last)
          state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      genome       <= '0;
      nflips       <= '0;
      idx          <= '0;
      rate         <= 8'h00;
      pend_vld     <= 1'b0;
      pend_seed_ld <= 1'b0;
      pend_rate    <= 8'h00;
      pend_seed    <= 32'h0;
    end else if (state == IDLE) begin
      pend_vld <= 1'b0;
      if (apply_now)
        rate <= eff_rate;
      if (accept) begin
        genome <= in_genome;
        nflips <= '0;
        idx    <= '0;
      end
    end else begin
      if (cfg_wr) begin
        pend_vld     <= 1'b1;
        pend_rate    <= cfg_rate;
        pend_seed_ld <= cfg_seed_ld;
        pend_seed    <= cfg_seed;
      end
      if (state == MUTATE) begin
        genome <= genome ^ flip_mask;
        idx    <= idx + IW'(1);
        if (hit)
          nflips <= nflips + NW'(1);
      end
    end
  end

`ifdef MUT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_flips   <= 16'h0;
      stat_genomes <= 16'h0;
    end else if (cfg_wr) begin
      stat_flips   <= 16'h0;
      stat_genomes <= 16'h0;
    end else begin
      if (hit && (stat_flips != 16'hFFFF))
        stat_flips <= stat_flips + 16'h1;
      if (out_valid && out_ready && (stat_genomes != 16'hFFFF))
        stat_genomes <= stat_genomes + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_genome_mutate.sv
// Scoreboard bench for genome_mutate: stimulus pushes expected outputs, a monitor pops on each handshake.
module tb_genome_mutate;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr, cfg_seed_ld;
  logic [7:0]  cfg_rate;
  logic [31:0] cfg_seed;
  logic        in_valid, in_ready;
  logic [63:0] in_genome;
  logic        out_valid, out_ready;
  logic [63:0] out_genome;
  logic [3:0]  out_nflips;
  logic        busy;

  genome_mutate dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_rate(cfg_rate), .cfg_seed_ld(cfg_seed_ld), .cfg_seed(cfg_seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_genome(in_genome),
    .out_valid(out_valid), .out_ready(out_ready), .out_genome(out_genome),
    .out_nflips(out_nflips), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_g[$];
  int          exp_n[$];

  logic [31:0] mlf;
  logic [7:0]  mrate;

  localparam logic [63:0] SEED1_MASK = 64'h0101_0101_0101_0101;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference mutation: one chunk per step, LFSR consumed then advanced.
  task automatic model_run(input logic [63:0] g, input logic [7:0] r, inout logic [31:0] lf,
                           output logic [63:0] o, output int nf);
    o  = g;
    nf = 0;
    for (int c = 0; c < 8; c++) begin
      if (lf[7:0] < r) begin
        o[c*8 + int'(lf[10:8])] = ~o[c*8 + int'(lf[10:8])];
        nf++;
      end
      lf = lf[0] ? ((lf >> 1) ^ 32'h8020_0003) : (lf >> 1);
    end
  endtask

  task automatic push_model(input logic [63:0] g);
    logic [63:0] o;
    int nf;
    model_run(g, mrate, mlf, o, nf);
    exp_g.push_back(o);
    exp_n.push_back(nf);
  endtask

  task automatic send(input logic [63:0] g);
    int k = 0;
    @(posedge clk); #1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid  = 1'b1;
    in_genome = g;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!(in_ready && !out_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check(nm, {63'b0, in_ready}, 64'd1);
  endtask

  task automatic cfg(input logic [7:0] r, input logic ld, input logic [31:0] s);
    @(posedge clk); #1;
    cfg_wr = 1'b1; cfg_rate = r; cfg_seed_ld = ld; cfg_seed = s;
    @(posedge clk); #1;
    cfg_wr = 1'b0; cfg_seed_ld = 1'b0;
  endtask

  // Monitor: every accepted output is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_g.size() == 0) begin
          check("unexpected_output", out_genome, 64'hx);
        end else begin
          logic [63:0] eg;
          int en;
          eg = exp_g.pop_front();
          en = exp_n.pop_front();
          check("sb_genome", out_genome, eg);
          check("sb_nflips", 64'(out_nflips), 64'(en));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g3_exp;
    logic [31:0] lf_tmp;
    int          n3_exp;
    int          lat;

    rst = 1'b0; cfg_wr = 1'b0; cfg_seed_ld = 1'b0; cfg_rate = 8'h0; cfg_seed = 32'h0;
    in_valid = 1'b0; in_genome = 64'h0; out_ready = 1'b1;
    mlf = 32'hACE1_0001; mrate = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",   {63'b0, in_ready},  64'd1);
    check("rst_out_valid",  {63'b0, out_valid}, 64'd0);
    check("rst_out_genome", out_genome,         64'd0);
    check("rst_out_nflips", 64'(out_nflips),    64'd0);
    check("rst_busy",       {63'b0, busy},      64'd0);
    rst = 1'b1;

    // 1: rate 0 passes the genome through, 8-cycle latency
    exp_g.push_back(64'hDEAD_BEEF_0123_4567);
    exp_n.push_back(0);
    lf_tmp = mlf; model_run(64'h0, mrate, lf_tmp, g3_exp, n3_exp); mlf = lf_tmp;
    send(64'hDEAD_BEEF_0123_4567);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd8);
    wait_idle("t1_idle");

    // 2: seed 1, rate 255 -> bit 0 of every chunk flips
    cfg(8'd255, 1'b1, 32'h1);
    mlf = 32'h1; mrate = 8'd255;
    exp_g.push_back(SEED1_MASK);
    exp_n.push_back(8);
    lf_tmp = mlf; model_run(64'h0, mrate, lf_tmp, g3_exp, n3_exp); mlf = lf_tmp;
    send(64'h0);
    wait_idle("t2_idle");

    // 3: backpressure holds output stable and blocks accept
    out_ready = 1'b0;
    lf_tmp = mlf;
    model_run(64'hFFFF_0000_A5A5_5A5A, mrate, lf_tmp, g3_exp, n3_exp);
    push_model(64'hFFFF_0000_A5A5_5A5A);
    send(64'hFFFF_0000_A5A5_5A5A);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid",  {63'b0, out_valid}, 64'd1);
      check("bp_out_genome", out_genome,         g3_exp);
      check("bp_out_nflips", 64'(out_nflips),    64'(n3_exp));
      check("bp_in_ready",   {63'b0, in_ready},  64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("t3_idle");

    // 4: zero seed becomes 1; two runs give identical results
    for (int r = 0; r < 2; r++) begin
      cfg(8'd255, 1'b1, 32'h0);
      mlf = 32'h1;
      exp_g.push_back(64'h1234_5678_9ABC_DEF0 ^ SEED1_MASK);
      exp_n.push_back(8);
      lf_tmp = mlf; model_run(64'h0, mrate, lf_tmp, g3_exp, n3_exp); mlf = lf_tmp;
      send(64'h1234_5678_9ABC_DEF0);
      wait_idle("t4_idle");
    end

    // 5: reset while chunk 3 is in progress drops the genome
    send(64'hCAFE_F00D_CAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'b0, in_ready},  64'd1);
    check("midrst_busy",      {63'b0, busy},      64'd0);
    check("midrst_genome",    out_genome,         64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mlf = 32'hACE1_0001; mrate = 8'h00;

    // 6: rate write during MUTATE is deferred to the next genome
    cfg(8'd255, 1'b1, 32'h1);
    mlf = 32'h1; mrate = 8'd255;
    exp_g.push_back(64'h0F0F_0F0F_F0F0_F0F0 ^ SEED1_MASK);
    exp_n.push_back(8);
    lf_tmp = mlf; model_run(64'h0, mrate, lf_tmp, g3_exp, n3_exp); mlf = lf_tmp;
    send(64'h0F0F_0F0F_F0F0_F0F0);
    cfg(8'd128, 1'b0, 32'h0);
    wait_idle("t6a_idle");
    mrate = 8'd128;
    push_model(64'h0123_4567_89AB_CDEF);
    send(64'h0123_4567_89AB_CDEF);
    wait_idle("t6b_idle");

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_g.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
